// File: rtl/pll_lock_sequencer.sv
// -----------------------------------------------------------------------------
// pll_lock_sequencer
//
// Brings up the system PLL from the 50 MHz reference clock. It pulses the PLL
// reset, waits for the PLL's locked flag (after synchronising it), requires the
// flag to stay high for a stable window, then releases the per-domain resets
// one at a time with a fixed gap between them. A timeout in WAIT_LOCK, a lock
// loss after release, or an explicit relock request all restart the sequence.
//
// Ports
//   refclk       in   1     reference clock, the only clock of this block
//   rst          in   1     asynchronous, active-high reset
//   pll_rst      out  1     reset to the PLL (high while holding it in reset)
//   pll_locked   in   1     PLL locked flag, asynchronous to refclk
//   relock_req   in   1     one-cycle pulse: restart the whole sequence
//   clr_err      in   1     one-cycle pulse: clear timeout_err and retry_cnt
//   dom_rst      out  NDOM  active-high domain resets, bit 0 released first
//   ready        out  1     every domain reset released and PLL locked
//   timeout_err  out  1     sticky flag: a lock timeout has occurred
//   retry_cnt    out  8     saturating count of timeouts plus lock losses
//
// The FSM state is held in the signal `state` for binding external checkers.
// -----------------------------------------------------------------------------
module pll_lock_sequencer #(
   parameter int RST_CYCLES    = 16,
   parameter int LOCK_TIMEOUT  = 65536,
   parameter int STABLE_CYCLES = 1024,
   parameter int RELEASE_GAP   = 256,
   parameter int NDOM          = 4
) (
   input  logic            refclk,
   input  logic            rst,
   output logic            pll_rst,
   input  logic            pll_locked,
   input  logic            relock_req,
   input  logic            clr_err,
   output logic [NDOM-1:0] dom_rst,
   output logic            ready,
   output logic            timeout_err,
   output logic [7:0]      retry_cnt
);

   localparam int MAX_AB  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
   localparam int MAX_CD  = (STABLE_CYCLES > RELEASE_GAP) ? STABLE_CYCLES : RELEASE_GAP;
   localparam int MAX_CNT = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int CW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
   localparam int IW      = (NDOM > 1) ? $clog2(NDOM) : 1;

   localparam logic [CW-1:0] HOLD_LAST    = CW'(RST_CYCLES - 1);
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
   localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LAST     = CW'(RELEASE_GAP - 1);
   localparam logic [IW-1:0] IDX_LAST     = IW'(NDOM - 1);

   typedef enum logic [2:0] {
      S_HOLD      = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_STABLE    = 3'd2,
      S_RELEASE   = 3'd3,
      S_RUN       = 3'd4
   } state_t;

   state_t          state, state_n;
   logic [CW-1:0]   cnt, cnt_n;
   logic [IW-1:0]   idx, idx_n;
   logic            pll_rst_n;
   logic [NDOM-1:0] dom_rst_n;
   logic            ready_n;
   logic            timeout_err_n;
   logic [7:0]      retry_cnt_n;
   logic            lock_meta, lock_s;
   logic            set_timeout;
   logic            inc_retry;

   // State register, registered outputs and the two-flop lock synchroniser.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         state       <= S_HOLD;
         cnt         <= '0;
         idx         <= '0;
         pll_rst     <= 1'b1;
         dom_rst     <= '1;
         ready       <= 1'b0;
         timeout_err <= 1'b0;
         retry_cnt   <= 8'd0;
         lock_meta   <= 1'b0;
         lock_s      <= 1'b0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         idx         <= idx_n;
         pll_rst     <= pll_rst_n;
         dom_rst     <= dom_rst_n;
         ready       <= ready_n;
         timeout_err <= timeout_err_n;
         retry_cnt   <= retry_cnt_n;
         lock_meta   <= pll_locked;
         lock_s      <= lock_meta;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      idx_n       = idx;
      pll_rst_n   = pll_rst;
      dom_rst_n   = dom_rst;
      ready_n     = ready;
      set_timeout = 1'b0;
      inc_retry   = 1'b0;

      if (relock_req) begin
         // A relock request overrides everything and restarts the hold count.
         state_n   = S_HOLD;
         cnt_n     = '0;
         pll_rst_n = 1'b1;
         dom_rst_n = '1;
         ready_n   = 1'b0;
      end else begin
         case (state)
            S_HOLD: begin
               pll_rst_n = 1'b1;
               if (cnt == HOLD_LAST) begin
                  state_n   = S_WAIT_LOCK;
                  cnt_n     = '0;
                  pll_rst_n = 1'b0;
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end

            S_WAIT_LOCK: begin
               if (lock_s) begin
                  state_n = S_STABLE;
                  cnt_n   = '0;
               end else if (cnt == TIMEOUT_LAST) begin
                  state_n     = S_HOLD;
                  cnt_n       = '0;
                  pll_rst_n   = 1'b1;
                  set_timeout = 1'b1;
                  inc_retry   = 1'b1;
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end

            S_STABLE: begin
               // A dropout before release is just a glitch: go back and wait,
               // without counting it as a retry.
               if (!lock_s) begin
                  state_n = S_WAIT_LOCK;
                  cnt_n   = '0;
               end else if (cnt == STABLE_LAST) begin
                  cnt_n        = '0;
                  idx_n        = '0;
                  dom_rst_n[0] = 1'b0;
                  if (IDX_LAST == '0) begin
                     state_n = S_RUN;
                     ready_n = 1'b1;
                  end else begin
                     state_n = S_RELEASE;
                  end
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end

            S_RELEASE: begin
               if (!lock_s) begin
                  state_n   = S_HOLD;
                  cnt_n     = '0;
                  pll_rst_n = 1'b1;
                  dom_rst_n = '1;
                  ready_n   = 1'b0;
                  inc_retry = 1'b1;
               end else if (cnt == GAP_LAST) begin
                  // idx never passes IDX_LAST: reaching it moves us to RUN.
                  cnt_n            = '0;
                  idx_n            = idx + 1'b1;
                  dom_rst_n[idx_n] = 1'b0;
                  if (idx_n == IDX_LAST) begin
                     state_n = S_RUN;
                     ready_n = 1'b1;
                  end
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end

            S_RUN: begin
               if (!lock_s) begin
                  state_n   = S_HOLD;
                  cnt_n     = '0;
                  pll_rst_n = 1'b1;
                  dom_rst_n = '1;
                  ready_n   = 1'b0;
                  inc_retry = 1'b1;
               end
            end

            default: begin
               state_n   = S_HOLD;
               cnt_n     = '0;
               pll_rst_n = 1'b1;
               dom_rst_n = '1;
               ready_n   = 1'b0;
            end
         endcase
      end

      // Error bookkeeping: an event on the same edge as clr_err wins, so the
      // clear is applied first and the event then lands on the cleared value.
      if (set_timeout) begin
         timeout_err_n = 1'b1;
      end else if (clr_err) begin
         timeout_err_n = 1'b0;
      end else begin
         timeout_err_n = timeout_err;
      end

      if (inc_retry) begin
         if (clr_err) begin
            retry_cnt_n = 8'd1;
         end else if (retry_cnt == 8'hFF) begin
            retry_cnt_n = 8'hFF;
         end else begin
            retry_cnt_n = retry_cnt + 8'd1;
         end
      end else if (clr_err) begin
         retry_cnt_n = 8'd0;
      end else begin
         retry_cnt_n = retry_cnt;
      end
   end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pll_lock_sequencer
//
// Directed bench for pll_lock_sequencer with RST_CYCLES=4, LOCK_TIMEOUT=32,
// STABLE_CYCLES=8, RELEASE_GAP=3, NDOM=4. Inputs change and outputs are
// sampled on the falling edge of refclk; the DUT acts on the rising edge.
// Edge numbers in the comments count rising edges from the last reference
// point (e.g. "S5" = fifth rising edge after reference S0).
// -----------------------------------------------------------------------------
module tb_pll_lock_sequencer;

   logic       refclk;
   logic       rst;
   logic       pll_rst;
   logic       pll_locked;
   logic       relock_req;
   logic       clr_err;
   logic [3:0] dom_rst;
   logic       ready;
   logic       timeout_err;
   logic [7:0] retry_cnt;

   int total = 0;
   int bad   = 0;

   pll_lock_sequencer #(
      .RST_CYCLES    (4),
      .LOCK_TIMEOUT  (32),
      .STABLE_CYCLES (8),
      .RELEASE_GAP   (3),
      .NDOM          (4)
   ) dut (
      .refclk      (refclk),
      .rst         (rst),
      .pll_rst     (pll_rst),
      .pll_locked  (pll_locked),
      .relock_req  (relock_req),
      .clr_err     (clr_err),
      .dom_rst     (dom_rst),
      .ready       (ready),
      .timeout_err (timeout_err),
      .retry_cnt   (retry_cnt)
   );

   // Clock: 10 ns period, rising edges at 5, 15, 25 ...
   initial begin
      refclk = 1'b0;
      forever #5 refclk = ~refclk;
   end

   // Advance n falling edges (each preceded by one rising edge).
   task automatic tick(input int n);
      repeat (n) @(negedge refclk);
   endtask

   task automatic pulse_relock();
      relock_req = 1'b1;
      tick(1);
      relock_req = 1'b0;
   endtask

   task automatic pulse_clr();
      clr_err = 1'b1;
      tick(1);
      clr_err = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst        = 1'b1;
      pll_locked = 1'b0;
      relock_req = 1'b0;
      clr_err    = 1'b0;
      tick(3);

      // Reset values.
      chk("rst_pll_rst", 32'(pll_rst), 32'd1);
      chk("rst_dom_rst", 32'(dom_rst), 32'hF);
      chk("rst_ready", 32'(ready), 32'd0);
      chk("rst_timeout_err", 32'(timeout_err), 32'd0);
      chk("rst_retry_cnt", 32'(retry_cnt), 32'd0);

      // Nominal start (reference P0): lock already high when rst releases.
      // HOLD P1..P4, WAIT P5, STABLE P5..P12, releases at P13/16/19/22.
      pll_locked = 1'b1;
      rst        = 1'b0;
      tick(3);
      chk("nom_pll_rst_p3", 32'(pll_rst), 32'd1);
      tick(1);
      chk("nom_pll_rst_p4", 32'(pll_rst), 32'd0);
      tick(8);
      chk("nom_dom_p12", 32'(dom_rst), 32'hF);
      tick(1);
      chk("nom_dom_p13", 32'(dom_rst), 32'hE);
      tick(2);
      chk("nom_dom_p15", 32'(dom_rst), 32'hE);
      tick(1);
      chk("nom_dom_p16", 32'(dom_rst), 32'hC);
      tick(3);
      chk("nom_dom_p19", 32'(dom_rst), 32'h8);
      tick(2);
      chk("nom_ready_p21", 32'(ready), 32'd0);
      tick(1);
      chk("nom_dom_p22", 32'(dom_rst), 32'h0);
      chk("nom_ready_p22", 32'(ready), 32'd1);
      chk("nom_retry_p22", 32'(retry_cnt), 32'd0);
      chk("nom_terr_p22", 32'(timeout_err), 32'd0);

      // Lock loss in RUN (reference Q0): 2 sync edges then 1 FSM edge.
      pll_locked = 1'b0;
      tick(2);
      chk("loss_ready_q2", 32'(ready), 32'd1);
      chk("loss_dom_q2", 32'(dom_rst), 32'h0);
      tick(1);
      chk("loss_dom_q3", 32'(dom_rst), 32'hF);
      chk("loss_ready_q3", 32'(ready), 32'd0);
      chk("loss_pll_rst_q3", 32'(pll_rst), 32'd1);
      chk("loss_retry_q3", 32'(retry_cnt), 32'd1);

      // Lock restored (reference R0 = HOLD with count 0): back in RUN at R22.
      pll_locked = 1'b1;
      tick(4);
      chk("reseq_pll_rst_r4", 32'(pll_rst), 32'd0);
      tick(18);
      chk("reseq_dom_r22", 32'(dom_rst), 32'h0);
      chk("reseq_ready_r22", 32'(ready), 32'd1);
      chk("reseq_retry_r22", 32'(retry_cnt), 32'd1);

      // relock_req from RUN: HOLD at S1, WAIT S5, STABLE S6, dom=1100 at S17.
      pulse_relock();
      chk("relock_dom_s1", 32'(dom_rst), 32'hF);
      chk("relock_pll_rst_s1", 32'(pll_rst), 32'd1);
      chk("relock_ready_s1", 32'(ready), 32'd0);
      chk("relock_retry_s1", 32'(retry_cnt), 32'd1);
      tick(4);
      chk("relock_pll_rst_s5", 32'(pll_rst), 32'd0);
      tick(12);
      chk("relock_dom_s17", 32'(dom_rst), 32'hC);

      // relock_req mid-RELEASE (reference T1 = HOLD, count 0).
      pulse_relock();
      chk("midrel_dom_t1", 32'(dom_rst), 32'hF);
      chk("midrel_pll_rst_t1", 32'(pll_rst), 32'd1);
      chk("midrel_retry_t1", 32'(retry_cnt), 32'd1);

      // Glitch in STABLE: STABLE from T6; one-cycle dropout seen by the FSM at
      // T12, back in STABLE at T13, so the release moves from T14 to T21.
      tick(8);
      pll_locked = 1'b0;
      tick(1);
      pll_locked = 1'b1;
      tick(4);
      chk("glitch_dom_t14", 32'(dom_rst), 32'hF);
      tick(6);
      chk("glitch_dom_t20", 32'(dom_rst), 32'hF);
      tick(1);
      chk("glitch_dom_t21", 32'(dom_rst), 32'hE);
      chk("glitch_retry_t21", 32'(retry_cnt), 32'd1);

      // Timeout: lock held low, relock to HOLD at U1, WAIT at U5, timeouts at
      // U37, U73, U109 ... every 36 cycles.
      pll_locked = 1'b0;
      pulse_relock();
      tick(3);
      chk("to_pll_rst_u4", 32'(pll_rst), 32'd1);
      tick(1);
      chk("to_pll_rst_u5", 32'(pll_rst), 32'd0);
      tick(31);
      chk("to_pll_rst_u36", 32'(pll_rst), 32'd0);
      chk("to_terr_u36", 32'(timeout_err), 32'd0);
      tick(1);
      chk("to_pll_rst_u37", 32'(pll_rst), 32'd1);
      chk("to_terr_u37", 32'(timeout_err), 32'd1);
      chk("to_retry_u37", 32'(retry_cnt), 32'd2);
      tick(36);
      chk("to_retry_u73", 32'(retry_cnt), 32'd3);

      // clr_err alone, then clr_err on the same edge as a timeout (U109).
      pulse_clr();
      chk("clr_terr_u74", 32'(timeout_err), 32'd0);
      chk("clr_retry_u74", 32'(retry_cnt), 32'd0);
      tick(34);
      chk("clr_terr_u108", 32'(timeout_err), 32'd0);
      clr_err = 1'b1;
      tick(1);
      clr_err = 1'b0;
      chk("clrto_terr_u109", 32'(timeout_err), 32'd1);
      chk("clrto_retry_u109", 32'(retry_cnt), 32'd1);

      // Saturation: one increment per 36-cycle attempt from retry_cnt=1.
      tick(253 * 36);
      chk("sat_retry_254", 32'(retry_cnt), 32'd254);
      tick(36);
      chk("sat_retry_255", 32'(retry_cnt), 32'd255);
      tick(36);
      chk("sat_retry_hold", 32'(retry_cnt), 32'd255);

      // Async rst mid-RELEASE: relock with lock high, HOLD at V1, dom=1100 at V17.
      pll_locked = 1'b1;
      pulse_relock();
      tick(16);
      chk("arst_dom_before", 32'(dom_rst), 32'hC);
      chk("arst_retry_before", 32'(retry_cnt), 32'd255);
      #2 rst = 1'b1;
      #1;
      chk("arst_pll_rst", 32'(pll_rst), 32'd1);
      chk("arst_dom_rst", 32'(dom_rst), 32'hF);
      chk("arst_ready", 32'(ready), 32'd0);
      chk("arst_terr", 32'(timeout_err), 32'd0);
      chk("arst_retry", 32'(retry_cnt), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
